// File: rtl/n64_joybus_pkg.sv
// Shared definitions for the N64 Joybus host and device blocks.
// Holds the line timing defaults (50 MHz clock), the host FSM state type,
// the standard command codes and the reply length expected for each command.
package n64_joybus_pkg;

  // Line timing in clock cycles at 50 MHz.
  localparam int unsigned CYC_1US     = 50;
  localparam int unsigned CYC_3US     = 150;
  localparam int unsigned SAMPLE_CYC  = 100;
  localparam int unsigned TIMEOUT_CYC = 5000;

  typedef enum logic [3:0] {
    StIdle,
    StTxLow,
    StTxHigh,
    StStopLow,
    StRxWait,
    StRxSample,
    StRxHigh,
    StStopRx,
    StDone
  } joy_state_e;

  // Command codes as sent in the first command byte.
  localparam logic [7:0] CmdInfo  = 8'h00;
  localparam logic [7:0] CmdPoll  = 8'h01;
  localparam logic [7:0] CmdRead  = 8'h02;
  localparam logic [7:0] CmdWrite = 8'h03;
  localparam logic [7:0] CmdReset = 8'hFF;

  // Reply length in bytes that a standard controller returns for a command.
  function automatic int unsigned reply_len(input logic [7:0] cmd);
    int unsigned len;
    len = 0;
    case (cmd)
      CmdInfo:  len = 3;
      CmdPoll:  len = 4;
      CmdRead:  len = 33;
      CmdWrite: len = 1;
      CmdReset: len = 3;
      default:  len = 0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/joybus_line_sync.sv
// Two-flop synchroniser for the asynchronous Joybus line, plus registered
// single-cycle rise/fall pulses derived from the synchronised level.
// Usable by both the host and the device side.
// Ports:
//   clock, reset_l : system clock, asynchronous active-low reset
//   line           : raw line level (asynchronous)
//   level          : synchronised line level
//   rise, fall     : one-cycle pulses on synchronised edges
module joybus_line_sync (
  input  logic clock,
  input  logic reset_l,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Flops reset to 1: an idle Joybus line is pulled high.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      meta_q <= line;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise   <= sync_q & ~prev_q;
      fall   <= ~sync_q & prev_q;
    end
  end

  assign level = sync_q;

endmodule

// File: rtl/n64_joybus_host.sv
// Host-side Joybus initiator for one controller port.
// Sends a 1-3 byte command MSB first followed by the host stop bit, then
// receives a 0-4 byte reply terminated by the device stop bit. A missing
// edge for the timeout period ends the transaction with timeout=1.
// Ports:
//   clock, reset_l          : system clock, asynchronous active-low reset
//   start                   : one-cycle request, honoured only when idle
//   tx_bytes, tx_data       : command length (0 means 1) and command bytes
//   rx_bytes                : expected reply length (values above 4 mean 4)
//   busy, done, timeout     : status; done is a one-cycle completion pulse
//   rx_data, rx_count       : right-justified reply and captured bit count
//   joy_drive_low, joy_in   : open-drain pad control and raw line level
module n64_joybus_host
  import n64_joybus_pkg::*;
#(
  parameter int unsigned Cyc1Us     = CYC_1US,
  parameter int unsigned Cyc3Us     = CYC_3US,
  parameter int unsigned SampleCyc  = SAMPLE_CYC,
  parameter int unsigned TimeoutCyc = TIMEOUT_CYC
) (
  input  logic        clock,
  input  logic        reset_l,
  input  logic        start,
  input  logic [1:0]  tx_bytes,
  input  logic [23:0] tx_data,
  input  logic [2:0]  rx_bytes,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] rx_data,
  output logic [5:0]  rx_count,
  output logic        joy_drive_low,
  input  logic        joy_in
);

  localparam int unsigned TimerW = $clog2(TimeoutCyc);

  // Reload values: a state holding value N-1 lasts exactly N cycles.
  localparam logic [TimerW-1:0] Load1Us     = TimerW'(Cyc1Us - 1);
  localparam logic [TimerW-1:0] Load3Us     = TimerW'(Cyc3Us - 1);
  localparam logic [TimerW-1:0] LoadSample  = TimerW'(SampleCyc - 1);
  localparam logic [TimerW-1:0] LoadTimeout = TimerW'(TimeoutCyc - 1);

  joy_state_e        state_q;
  logic [TimerW-1:0] timer_q;
  logic [4:0]        bit_idx_q;
  logic [4:0]        tx_bits_q;
  logic [5:0]        rx_bits_q;
  logic [23:0]       tx_shift_q;

  logic line_level;
  logic line_rise;
  logic line_fall;

  joybus_line_sync u_line_sync (
    .clock   (clock),
    .reset_l (reset_l),
    .line    (joy_in),
    .level   (line_level),
    .rise    (line_rise),
    .fall    (line_fall)
  );

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      bit_idx_q     <= '0;
      tx_bits_q     <= '0;
      rx_bits_q     <= '0;
      tx_shift_q    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout       <= 1'b0;
      rx_data       <= '0;
      rx_count      <= '0;
      joy_drive_low <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            tx_shift_q    <= tx_data;
            tx_bits_q     <= (tx_bytes == 2'd0) ? 5'd8 : {tx_bytes, 3'b000};
            rx_bits_q     <= (rx_bytes > 3'd4) ? 6'd32 : {rx_bytes, 3'b000};
            bit_idx_q     <= '0;
            rx_data       <= '0;
            rx_count      <= '0;
            timeout       <= 1'b0;
            busy          <= 1'b1;
            joy_drive_low <= 1'b1;
            // A 1 bit has the short low phase, a 0 bit the long one.
            timer_q       <= tx_data[23] ? Load1Us : Load3Us;
            state_q       <= StTxLow;
          end
        end

        StTxLow: begin
          if (timer_q == '0) begin
            joy_drive_low <= 1'b0;
            timer_q       <= tx_shift_q[23] ? Load3Us : Load1Us;
            state_q       <= StTxHigh;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end

        StTxHigh: begin
          if (timer_q == '0) begin
            joy_drive_low <= 1'b1;
            if (bit_idx_q == tx_bits_q - 5'd1) begin
              timer_q <= Load1Us;
              state_q <= StStopLow;
            end else begin
              bit_idx_q  <= bit_idx_q + 5'd1;
              tx_shift_q <= {tx_shift_q[22:0], 1'b0};
              timer_q    <= tx_shift_q[22] ? Load1Us : Load3Us;
              state_q    <= StTxLow;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end

        StStopLow: begin
          if (timer_q == '0) begin
            joy_drive_low <= 1'b0;
            if (rx_bits_q == '0) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_q <= StDone;
            end else begin
              timer_q <= LoadTimeout;
              state_q <= StRxWait;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end

        StRxWait: begin
          if (line_fall) begin
            // Once every data bit is in, the next low pulse is the stop bit.
            if (rx_count == rx_bits_q) begin
              timer_q <= LoadTimeout;
              state_q <= StStopRx;
            end else begin
              timer_q <= LoadSample;
              state_q <= StRxSample;
            end
          end else if (timer_q == '0) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end

        StRxSample: begin
          if (timer_q == '0) begin
            rx_data  <= {rx_data[30:0], line_level};
            rx_count <= rx_count + 6'd1;
            timer_q  <= LoadTimeout;
            // A 0 bit is still low here; its rising edge must pass first.
            state_q  <= line_level ? StRxWait : StRxHigh;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end

        StRxHigh: begin
          if (line_rise) begin
            timer_q <= LoadTimeout;
            state_q <= StRxWait;
          end else if (timer_q == '0) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end

        StStopRx: begin
          if (line_rise) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end else if (timer_q == '0) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          joy_drive_low <= 1'b0;
          busy          <= 1'b0;
          state_q       <= StIdle;
        end
      endcase
    end
  end

endmodule
